// File: rtl/io_bus_bridge.sv
// rtl/io_bus_bridge.sv - MEM-stage bridge routing CPU data accesses to DRAM or on-board IO
// Owns LED/display/timer registers, the display scan and the switch/button synchronizers.
module io_bus_bridge #(
    parameter int          SCAN_CYCLES = 20000,
    parameter logic [31:0] DIV_RESET   = 32'd99
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_wen,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic [13:0] dram_addr,
    output logic        dram_wen,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    input  logic [4:0]  btn,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);
    localparam int             SCW       = $clog2(SCAN_CYCLES);
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_CYCLES - 1);

    localparam logic [11:0] OFF_DIG  = 12'h000;
    localparam logic [11:0] OFF_TCNT = 12'h020;
    localparam logic [11:0] OFF_TDIV = 12'h024;
    localparam logic [11:0] OFF_LED  = 12'h060;
    localparam logic [11:0] OFF_SW   = 12'h070;
    localparam logic [11:0] OFF_BTN  = 12'h078;

    logic [31:0]    dig_reg;
    logic [31:0]    tcnt;
    logic [31:0]    tdiv;
    logic [31:0]    pcnt;
    logic [23:0]    sw_meta, sw_sync;
    logic [4:0]     btn_meta, btn_sync;
    logic [SCW-1:0] scnt;
    logic [2:0]     idx;

    logic        io_sel;
    logic [11:0] off;
    logic        wr_io, wr_tcnt, wr_tdiv;

    assign io_sel     = (Bus_addr[31:12] == 20'hFFFFF);
    assign off        = Bus_addr[11:0];
    assign dram_addr  = Bus_addr[15:2];
    assign dram_wen   = Bus_wen & ~io_sel;
    assign dram_wdata = Bus_wdata;

    assign wr_io   = Bus_wen & io_sel;
    assign wr_tcnt = wr_io && (off == OFF_TCNT);
    assign wr_tdiv = wr_io && (off == OFF_TDIV);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        Bus_rdata = 32'h0;
        if (!io_sel) begin
            Bus_rdata = dram_rdata;
        end else begin
            case (off)
                OFF_DIG:  Bus_rdata = dig_reg;
                OFF_TCNT: Bus_rdata = tcnt;
                OFF_TDIV: Bus_rdata = tdiv;
                OFF_LED:  Bus_rdata = {8'h0, led};
                OFF_SW:   Bus_rdata = {8'h0, sw_sync};
                OFF_BTN:  Bus_rdata = {27'h0, btn_sync};
                default:  Bus_rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            dig_reg <= 32'h0;
            led     <= 24'h0;
        end else begin
            if (wr_io && (off == OFF_DIG)) dig_reg <= Bus_wdata;
            if (wr_io && (off == OFF_LED)) led     <= Bus_wdata[23:0];
        end
    end

    // Any timer write restarts the prescaler and suppresses that cycle's tick.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            tcnt <= 32'h0;
            tdiv <= DIV_RESET;
            pcnt <= 32'h0;
        end else if (wr_tcnt || wr_tdiv) begin
            if (wr_tcnt) tcnt <= Bus_wdata;
            if (wr_tdiv) tdiv <= Bus_wdata;
            pcnt <= 32'h0;
        end else if (pcnt == tdiv) begin
            pcnt <= 32'h0;
            tcnt <= tcnt + 32'd1;
        end else begin
            pcnt <= pcnt + 32'd1;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            sw_meta  <= 24'h0;
            sw_sync  <= 24'h0;
            btn_meta <= 5'h0;
            btn_sync <= 5'h0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            scnt    <= '0;
            idx     <= 3'd0;
            dig_en  <= 8'hFE;
            dig_seg <= 8'hC0;
        end else begin
            if (scnt == SCAN_LAST) begin
                scnt <= '0;
                idx  <= idx + 3'd1;
            end else begin
                scnt <= scnt + SCW'(1);
            end
            dig_en  <= ~(8'b1 << idx);
            dig_seg <= {1'b1, ~hex7(dig_reg[{idx, 2'b00} +: 4])};
        end
    end
endmodule

// File: tb/tb_io_bus_bridge.sv
// tb/tb_io_bus_bridge.sv - scoreboard bench for io_bus_bridge against a time-based reference model
module tb_io_bus_bridge;
    localparam int SCAN = 4;
    localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic [31:0] Bus_addr, Bus_wdata, Bus_rdata, dram_wdata, dram_rdata;
    logic        Bus_wen, dram_wen;
    logic [13:0] dram_addr;
    logic [23:0] sw, led;
    logic [4:0]  btn;
    logic [7:0]  dig_en, dig_seg;

    io_bus_bridge #(.SCAN_CYCLES(SCAN), .DIV_RESET(32'd99)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .Bus_addr(Bus_addr), .Bus_wen(Bus_wen), .Bus_wdata(Bus_wdata), .Bus_rdata(Bus_rdata),
        .dram_addr(dram_addr), .dram_wen(dram_wen), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
        .sw(sw), .btn(btn), .led(led), .dig_en(dig_en), .dig_seg(dig_seg)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [31:0] rdata;
        logic        wen;
        logic [13:0] daddr;
        logic [31:0] dwdata;
        logic [23:0] led;
        logic [7:0]  en;
        logic [7:0]  seg;
    } exp_t;

    exp_t        q[$];
    int unsigned total  = 0;
    int unsigned passed = 0;

    // Reference state: t = posedges since reset release; timer is base + elapsed/(tdiv+1).
    longint      t, t_load;
    logic [31:0] base_m, tdiv_m, dig_m, dig_prev_m;
    logic [23:0] led_m;
    logic [23:0] sw_at  [0:8191];
    logic [4:0]  btn_at [0:8191];

    function automatic logic [31:0] tcnt_m();
        return base_m + 32'((t - t_load) / (longint'(tdiv_m) + 64'sd1));
    endfunction

    function automatic exp_t expect_now(logic [31:0] a, logic w, logic [31:0] d, logic [31:0] drd);
        exp_t e;
        int   di;
        logic io;
        io       = (a[31:12] == 20'hFFFFF);
        e.wen    = w & !io;
        e.daddr  = a[15:2];
        e.dwdata = d;
        e.led    = led_m;
        if (!io) e.rdata = drd;
        else begin
            case (a[11:0])
                12'h000: e.rdata = dig_m;
                12'h020: e.rdata = tcnt_m();
                12'h024: e.rdata = tdiv_m;
                12'h060: e.rdata = {8'h0, led_m};
                12'h070: e.rdata = (t >= 2) ? {8'h0, sw_at[int'(t - 2)]} : 32'h0;
                12'h078: e.rdata = (t >= 2) ? {27'h0, btn_at[int'(t - 2)]} : 32'h0;
                default: e.rdata = 32'h0;
            endcase
        end
        di    = (t == 0) ? 0 : int'(((t - 1) / SCAN) % 8);
        e.en  = ~(8'h01 << di);
        e.seg = {1'b1, ~SEG[dig_prev_m[4*di +: 4]]};
        return e;
    endfunction

    task automatic model_reset();
        t = 0; t_load = 0; base_m = 32'h0; tdiv_m = 32'd99;
        dig_m = 32'h0; dig_prev_m = 32'h0; led_m = 24'h0;
    endtask

    task automatic model_edge(input logic [31:0] a, input logic w, input logic [31:0] d);
        logic [31:0] tc;
        tc         = tcnt_m();
        dig_prev_m = dig_m;
        t          = t + 1;
        if (w && a[31:12] == 20'hFFFFF) begin
            case (a[11:0])
                12'h000: dig_m = d;
                12'h020: begin base_m = d; t_load = t; end
                12'h024: begin base_m = tc; tdiv_m = d; t_load = t; end
                12'h060: led_m = d[23:0];
                default: ;
            endcase
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d);
        Bus_addr   = a;
        Bus_wen    = w;
        Bus_wdata  = d;
        dram_rdata = $urandom;
        sw_at[int'(t)]  = sw;
        btn_at[int'(t)] = btn;
        q.push_back(expect_now(a, w, d, dram_rdata));
        @(posedge cpu_clk);
        if (cpu_rst) model_edge(a, w, d);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
        else passed++;
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle against live outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge cpu_clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rdata",      Bus_rdata,                e.rdata);
                chk("dram_wen",   {31'h0, dram_wen},        {31'h0, e.wen});
                chk("dram_addr",  {18'h0, dram_addr},       {18'h0, e.daddr});
                chk("dram_wdata", dram_wdata,               e.dwdata);
                chk("led",        {8'h0, led},              {8'h0, e.led});
                chk("dig_en",     {24'h0, dig_en},          {24'h0, e.en});
                chk("dig_seg",    {24'h0, dig_seg},         {24'h0, e.seg});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    localparam logic [31:0] IO = 32'hFFFFF000;

    initial begin
        logic [31:0] a, d;
        logic        w;
        int          r;
        logic [31:0] unm [4] = '{32'h004, 32'h100, 32'hFFC, 32'h064};

        cpu_rst = 1'b0; Bus_addr = 32'h0; Bus_wen = 1'b0; Bus_wdata = 32'h0;
        dram_rdata = 32'h0; sw = 24'h0; btn = 5'h0;
        model_reset();
        @(posedge cpu_clk); #1;
        drive(IO | 32'h020, 1'b0, 32'h0);
        cpu_rst = 1'b1;

        drive(32'h0000_0010, 1'b1, 32'hDEADBEEF);
        drive(32'h0000_0010, 1'b0, 32'h0);

        drive(IO | 32'h060, 1'b1, 32'h00A5A5A5);
        drive(IO | 32'h060, 1'b0, 32'h0);
        drive(IO | 32'h100, 1'b1, 32'h12345678);
        drive(IO | 32'h100, 1'b0, 32'h0);
        drive(32'hFFFFE060, 1'b1, 32'h00000001);

        drive(IO | 32'h024, 1'b1, 32'd3);
        for (int i = 0; i < 9; i++) drive(IO | 32'h020, 1'b0, 32'h0);
        drive(IO | 32'h020, 1'b1, 32'hFFFFFFFF);
        for (int i = 0; i < 6; i++) drive(IO | 32'h020, 1'b0, 32'h0);
        drive(IO | 32'h024, 1'b1, 32'd3);
        for (int i = 0; i < 3; i++) drive(IO | 32'h020, 1'b0, 32'h0);
        drive(IO | 32'h020, 1'b1, 32'h55);
        for (int i = 0; i < 2; i++) drive(IO | 32'h020, 1'b0, 32'h0);

        sw = 24'h123456; btn = 5'h15;
        for (int i = 0; i < 4; i++) drive(IO | 32'h070, 1'b0, 32'h0);
        drive(IO | 32'h078, 1'b0, 32'h0);

        drive(IO | 32'h000, 1'b1, 32'h89ABCDEF);
        for (int i = 0; i < 36; i++) drive(IO | 32'h000, 1'b0, 32'h0);

        drive(IO | 32'h024, 1'b1, 32'd1000);
        drive(IO | 32'h020, 1'b1, 32'd5);
        drive(IO | 32'h020, 1'b0, 32'h0);
        cpu_rst = 1'b0;
        model_reset();
        drive(IO | 32'h020, 1'b0, 32'h0);
        drive(IO | 32'h024, 1'b0, 32'h0);
        cpu_rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(IO | 32'h020, 1'b0, 32'h0);
        drive(IO | 32'h024, 1'b1, 32'd0);
        for (int i = 0; i < 4; i++) drive(IO | 32'h020, 1'b0, 32'h0);

        for (int i = 0; i < 600; i++) begin
            if (i % 7 == 0) begin sw = 24'($urandom); btn = 5'($urandom); end
            r = $urandom_range(0, 11);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            case (r)
                0, 1, 2: a = $urandom & 32'h7FFF_FFFC;
                3, 11:   a = IO | 32'h000;
                4:       a = IO | 32'h020;
                5:       begin a = IO | 32'h024; d = $urandom_range(0, 5); end
                6:       a = IO | 32'h060;
                7:       a = IO | 32'h070;
                8:       a = IO | 32'h078;
                9:       a = IO | unm[$urandom_range(0, 3)];
                default: a = 32'hFFFFE000 | ($urandom & 32'hFFC);
            endcase
            drive(a, w, d);
        end

        @(negedge cpu_clk); #1;
        chk("queue_drained", q.size(), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
